// File: rtl/cpu_control_seq.sv
// Moore control sequencer: decodes IR[31:27] and steps through per-instruction datapath control words.
// Latency: fetch is 3 states, execute 1..5 states; every memory wait cycle adds one cycle.
// Backpressure: memory states hold while Mem_ready=0; after MEM_TIMEOUT waits the block faults.
module cpu_control_seq #(
  parameter int NREG        = 16,
  parameter int LINK_REG    = 14,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic            Clock,
  input  logic            Reset,
  input  logic [31:0]     IR,
  input  logic            CON_ff,
  input  logic            Mem_ready,
  input  logic            Stop,
  input  logic            Resume,
  output logic [9:0]      Drive,
  output logic [11:0]     Load,
  output logic [2:0]      Sel,
  output logic            IncPC,
  output logic            MDR_read,
  output logic            Mem_req,
  output logic [NREG-1:0] R_enableIn,
  output logic            Run,
  output logic            Fault
);

  // Bus source bit positions
  localparam int D_PC = 0, D_MDR = 1, D_ZH = 2, D_ZL = 3, D_HI = 4;
  localparam int D_LO = 5, D_IN = 6, D_C = 7, D_R = 8, D_BA = 9;
  // Register load bit positions
  localparam int L_MAR = 0, L_MDR = 1, L_IR = 2, L_Y = 3, L_PC = 4, L_HI = 5;
  localparam int L_LO = 6, L_Z = 7, L_REN = 8, L_CON = 9, L_OUT = 10, L_RAM = 11;
  // Register-select encodings {Gra,Grb,Grc}
  localparam logic [2:0] GRA = 3'b100, GRB = 3'b010, GRC = 3'b001;
  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  typedef enum logic [5:0] {
    S_RST, S_F0, S_F1, S_F2,
    S_A3_1, S_A3_2, S_A3_3,
    S_IM_1, S_IM_2, S_IM_3,
    S_MD_1, S_MD_2, S_MD_3, S_MD_4,
    S_A2_1, S_A2_2,
    S_LD_1, S_LD_2, S_LD_3, S_LD_4, S_LD_5,
    S_LDI_1, S_LDI_2, S_LDI_3,
    S_ST_1, S_ST_2, S_ST_3, S_ST_4, S_ST_5,
    S_BR_1, S_BR_2, S_BR_3, S_BR_4,
    S_JR, S_JAL_1, S_JAL_2,
    S_MFHI, S_MFLO, S_IN, S_OUT, S_NOP,
    S_HALT, S_ILL, S_FLT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt;
  logic       fault_q;
  state_t     boundary;
  logic       timed_out;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign boundary  = Stop ? S_HALT : S_F0;
  assign timed_out = (wait_cnt == TIMEOUT);
  assign Fault     = fault_q;

  // State register; Reset forces RST without waiting for a clock
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) state_q <= S_RST;
    else       state_q <= state_d;
  end

  // Memory wait counter: zero outside memory states, counts cycles without Mem_ready inside them
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)             wait_cnt <= '0;
    else if (!Mem_req)     wait_cnt <= '0;
    else if (!Mem_ready)   wait_cnt <= wait_cnt + 8'd1;
  end

  // Sticky fault flag, set on the edge that enters ILL or FLT
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset)                                    fault_q <= 1'b0;
    else if (state_d == S_ILL || state_d == S_FLT) fault_q <= 1'b1;
  end

  // Next-state: fetch, opcode decode, per-instruction sequencing, memory waits and halt/fault
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RST:   state_d = S_F0;
      S_F0:    state_d = S_F1;
      S_F1:    if (Mem_ready) state_d = S_F2; else if (timed_out) state_d = S_FLT;
      S_F2: begin
        case (opcode)
          5'b00000: state_d = S_LD_1;
          5'b00001: state_d = S_LDI_1;
          5'b00010: state_d = S_ST_1;
          5'b00011, 5'b00100, 5'b00101, 5'b00110,
          5'b00111, 5'b01000, 5'b01001, 5'b01010: state_d = S_A3_1;
          5'b01011, 5'b01100, 5'b01101: state_d = S_IM_1;
          5'b01110, 5'b01111: state_d = S_MD_1;
          5'b10000, 5'b10001: state_d = S_A2_1;
          5'b10010: state_d = S_BR_1;
          5'b10011: state_d = S_JR;
          5'b10100: state_d = S_JAL_1;
          5'b10101: state_d = S_IN;
          5'b10110: state_d = S_OUT;
          5'b10111: state_d = S_MFHI;
          5'b11000: state_d = S_MFLO;
          5'b11001: state_d = S_NOP;
          5'b11010: state_d = S_HALT;
          default:  state_d = S_ILL;
        endcase
      end
      S_A3_1:  state_d = S_A3_2;
      S_A3_2:  state_d = S_A3_3;
      S_IM_1:  state_d = S_IM_2;
      S_IM_2:  state_d = S_IM_3;
      S_MD_1:  state_d = S_MD_2;
      S_MD_2:  state_d = S_MD_3;
      S_MD_3:  state_d = S_MD_4;
      S_A2_1:  state_d = S_A2_2;
      S_LD_1:  state_d = S_LD_2;
      S_LD_2:  state_d = S_LD_3;
      S_LD_3:  state_d = S_LD_4;
      S_LD_4:  if (Mem_ready) state_d = S_LD_5; else if (timed_out) state_d = S_FLT;
      S_LDI_1: state_d = S_LDI_2;
      S_LDI_2: state_d = S_LDI_3;
      S_ST_1:  state_d = S_ST_2;
      S_ST_2:  state_d = S_ST_3;
      S_ST_3:  state_d = S_ST_4;
      S_ST_4:  state_d = S_ST_5;
      S_ST_5:  if (Mem_ready) state_d = boundary; else if (timed_out) state_d = S_FLT;
      S_BR_1:  state_d = S_BR_2;
      S_BR_2:  state_d = S_BR_3;
      S_BR_3:  state_d = S_BR_4;
      S_JAL_1: state_d = S_JAL_2;
      S_A3_3, S_IM_3, S_MD_4, S_A2_2, S_LD_5, S_LDI_3, S_BR_4, S_JR, S_JAL_2,
      S_MFHI, S_MFLO, S_IN, S_OUT, S_NOP: state_d = boundary;
      // Stop wins over Resume so a held Stop keeps the processor parked
      S_HALT:  if (Resume && !Stop) state_d = S_F0;
      S_ILL:   state_d = S_ILL;
      S_FLT:   state_d = S_FLT;
      default: state_d = S_RST;
    endcase
  end

  // Moore output decode; only BR_4 additionally looks at CON_ff
  always_comb begin
    Drive      = '0;
    Load       = '0;
    Sel        = '0;
    IncPC      = 1'b0;
    MDR_read   = 1'b0;
    Mem_req    = 1'b0;
    R_enableIn = '0;
    Run        = 1'b1;
    case (state_q)
      S_F0:    begin Drive[D_PC] = 1'b1; Load[L_MAR] = 1'b1; end
      S_F1:    begin Load[L_MDR] = 1'b1; MDR_read = 1'b1; Mem_req = 1'b1; end
      S_F2:    begin Drive[D_MDR] = 1'b1; Load[L_IR] = 1'b1; Load[L_PC] = 1'b1; IncPC = 1'b1; end
      S_A3_1, S_IM_1, S_MD_1: begin Sel = GRB; Drive[D_R] = 1'b1; Load[L_Y] = 1'b1; end
      S_A3_2, S_MD_2: begin Sel = GRC; Drive[D_R] = 1'b1; Load[L_Z] = 1'b1; end
      S_IM_2, S_LD_2, S_LDI_2, S_ST_2, S_BR_3: begin Drive[D_C] = 1'b1; Load[L_Z] = 1'b1; end
      S_A3_3, S_IM_3, S_A2_2, S_LDI_3: begin Drive[D_ZL] = 1'b1; Sel = GRA; Load[L_REN] = 1'b1; end
      S_MD_3:  begin Drive[D_ZL] = 1'b1; Load[L_LO] = 1'b1; end
      S_MD_4:  begin Drive[D_ZH] = 1'b1; Load[L_HI] = 1'b1; end
      S_A2_1:  begin Sel = GRB; Drive[D_R] = 1'b1; Load[L_Z] = 1'b1; end
      S_LD_1, S_LDI_1, S_ST_1: begin Sel = GRB; Drive[D_BA] = 1'b1; Load[L_Y] = 1'b1; end
      S_LD_3, S_ST_3: begin Drive[D_ZL] = 1'b1; Load[L_MAR] = 1'b1; end
      S_LD_4:  begin Load[L_MDR] = 1'b1; MDR_read = 1'b1; Mem_req = 1'b1; end
      S_LD_5:  begin Drive[D_MDR] = 1'b1; Sel = GRA; Load[L_REN] = 1'b1; end
      S_ST_4:  begin Sel = GRA; Drive[D_R] = 1'b1; Load[L_MDR] = 1'b1; end
      S_ST_5:  begin Drive[D_MDR] = 1'b1; Load[L_RAM] = 1'b1; Mem_req = 1'b1; end
      S_BR_1:  begin Sel = GRA; Drive[D_R] = 1'b1; Load[L_CON] = 1'b1; end
      S_BR_2:  begin Drive[D_PC] = 1'b1; Load[L_Y] = 1'b1; end
      S_BR_4:  begin Drive[D_ZL] = 1'b1; Load[L_PC] = CON_ff; end
      S_JR, S_JAL_2: begin Sel = GRA; Drive[D_R] = 1'b1; Load[L_PC] = 1'b1; end
      S_JAL_1: begin Drive[D_PC] = 1'b1; R_enableIn[LINK_REG] = 1'b1; end
      S_MFHI:  begin Sel = GRA; Drive[D_HI] = 1'b1; Load[L_REN] = 1'b1; end
      S_MFLO:  begin Sel = GRA; Drive[D_LO] = 1'b1; Load[L_REN] = 1'b1; end
      S_IN:    begin Sel = GRA; Drive[D_IN] = 1'b1; Load[L_REN] = 1'b1; end
      S_OUT:   begin Sel = GRA; Drive[D_R] = 1'b1; Load[L_OUT] = 1'b1; end
      S_HALT, S_ILL, S_FLT: Run = 1'b0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cpu_control_seq.sv
// Bench for cpu_control_seq: per-cycle expected control words queued at stimulus time, compared at negedge.
// Latency: expected word for a cycle is checked half a clock after the edge that produced it.
// Backpressure: Mem_ready is driven per cycle to exercise waits, the timeout boundary and the fault path.
module tb_cpu_control_seq;
  localparam int NREG = 16;

  logic            Clock = 1'b0;
  logic            Reset = 1'b1;
  logic [31:0]     IR = '0;
  logic            CON_ff = 1'b0, Mem_ready = 1'b1, Stop = 1'b0, Resume = 1'b0;
  logic [9:0]      Drive;
  logic [11:0]     Load;
  logic [2:0]      Sel;
  logic            IncPC, MDR_read, Mem_req, Run, Fault;
  logic [NREG-1:0] R_enableIn;

  cpu_control_seq #(.NREG(NREG), .LINK_REG(14), .MEM_TIMEOUT(15)) dut (
    .Clock(Clock), .Reset(Reset), .IR(IR), .CON_ff(CON_ff), .Mem_ready(Mem_ready),
    .Stop(Stop), .Resume(Resume), .Drive(Drive), .Load(Load), .Sel(Sel), .IncPC(IncPC),
    .MDR_read(MDR_read), .Mem_req(Mem_req), .R_enableIn(R_enableIn), .Run(Run), .Fault(Fault)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic [9:0]  drive;
    logic [11:0] load;
    logic [2:0]  sel;
    logic        incpc, mdr_read, mem_req;
    logic [15:0] ren;
    logic        run, fault;
  } cw_t;

  typedef struct packed { logic [31:0] ir; logic con; logic [3:0] n; } vec_t;
  typedef struct { cw_t w; int id; } sb_t;

  localparam int DPC = 0, DMDR = 1, DZH = 2, DZL = 3, DHI = 4, DLO = 5, DIN = 6, DC = 7, DR = 8, DBA = 9;
  localparam logic [11:0] LMAR = 12'h001, LMDR = 12'h002, LIR = 12'h004, LY = 12'h008, LPC = 12'h010,
                          LHI = 12'h020, LLO = 12'h040, LZ = 12'h080, LREN = 12'h100, LCON = 12'h200,
                          LOUT = 12'h400, LRAM = 12'h800;
  localparam logic [2:0] GA = 3'b100, GB = 3'b010, GC = 3'b001;
  localparam logic [2:0] FINC = 3'b100, FRD = 3'b010, FMEM = 3'b001;

  cw_t  act;
  sb_t  sbq[$];
  int   total = 0, bad = 0, step_id = 0, nv = 0;
  vec_t tv[24];
  cw_t  body[24][5];
  cw_t  fw[3];
  cw_t  RSTW, HALTW, FLTW, X0, GRBY, GRCZ, ZLGA, CZ, BAY, ZLMAR, LDRD, JAL1;

  always_comb act = {Drive, Load, Sel, IncPC, MDR_read, Mem_req, R_enableIn, Run, Fault};

  function automatic cw_t w(input int d, input logic [11:0] ld, input logic [2:0] sl, input logic [2:0] f);
    cw_t c;
    c = '0;
    if (d >= 0) c.drive = 10'b1 << d;
    c.load = ld;
    c.sel = sl;
    {c.incpc, c.mdr_read, c.mem_req} = f;
    c.run = 1'b1;
    return c;
  endfunction

  task automatic check(input cw_t e, input int id);
    total++;
    if (act !== e) begin
      bad++;
      $display("FAIL step%0d ctrl_word got=%h want=%h", id, act, e);
    end
    total++;
    if ($countones(Drive) > 1) begin
      bad++;
      $display("FAIL step%0d drive_onehot got=%b want=at most one bit", id, Drive);
    end
  endtask

  task automatic add_vec(input logic [31:0] ir, input logic con, input logic [3:0] n,
                         input cw_t b0, input cw_t b1, input cw_t b2, input cw_t b3, input cw_t b4);
    tv[nv] = '{ir: ir, con: con, n: n};
    body[nv][0] = b0; body[nv][1] = b1; body[nv][2] = b2; body[nv][3] = b3; body[nv][4] = b4;
    nv++;
  endtask

  // One clock: drive inputs just after the edge and queue the word the DUT should show this cycle
  task automatic cyc(input cw_t e, input logic [31:0] ir, input logic con, input logic mr,
                     input logic stp, input logic res);
    sb_t s;
    @(posedge Clock);
    #1;
    IR = ir; CON_ff = con; Mem_ready = mr; Stop = stp; Resume = res;
    step_id++;
    s.w = e;
    s.id = step_id;
    sbq.push_back(s);
  endtask

  task automatic do_reset(input int id);
    @(negedge Clock);
    #1;
    Reset = 1'b1;
    #1;
    check(RSTW, id);
    @(negedge Clock);
    #1;
    check(RSTW, id + 1);
    Reset = 1'b0; Stop = 1'b0; Resume = 1'b0; Mem_ready = 1'b1;
    #1;
    check(RSTW, id + 2);
  endtask

  always @(negedge Clock) begin
    sb_t s;
    if (sbq.size() > 0) begin
      s = sbq.pop_front();
      check(s.w, s.id);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired got=running want=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    RSTW  = w(-1, 12'h0, 3'b0, 3'b0);
    HALTW = '0;
    FLTW  = '0; FLTW.fault = 1'b1;
    X0    = '0;
    fw[0] = w(DPC, LMAR, 3'b0, 3'b0);
    fw[1] = w(-1, LMDR, 3'b0, FRD | FMEM);
    fw[2] = w(DMDR, LIR | LPC, 3'b0, FINC);
    GRBY  = w(DR, LY, GB, 3'b0);
    GRCZ  = w(DR, LZ, GC, 3'b0);
    ZLGA  = w(DZL, LREN, GA, 3'b0);
    CZ    = w(DC, LZ, 3'b0, 3'b0);
    BAY   = w(DBA, LY, GB, 3'b0);
    ZLMAR = w(DZL, LMAR, 3'b0, 3'b0);
    LDRD  = w(-1, LMDR, 3'b0, FRD | FMEM);
    JAL1  = w(DPC, 12'h0, 3'b0, 3'b0); JAL1.ren = 16'h4000;

    add_vec(32'h18000000, 0, 6, GRBY, GRCZ, ZLGA, X0, X0);                         // add
    add_vec(32'h50000000, 0, 6, GRBY, GRCZ, ZLGA, X0, X0);                         // or
    add_vec(32'h58000000, 0, 6, GRBY, CZ, ZLGA, X0, X0);                           // addi
    add_vec(32'h68000000, 0, 6, GRBY, CZ, ZLGA, X0, X0);                           // ori
    add_vec(32'h70000000, 0, 7, GRBY, GRCZ, w(DZL, LLO, 0, 0), w(DZH, LHI, 0, 0), X0); // mul
    add_vec(32'h78000000, 0, 7, GRBY, GRCZ, w(DZL, LLO, 0, 0), w(DZH, LHI, 0, 0), X0); // div
    add_vec(32'h80000000, 0, 5, w(DR, LZ, GB, 0), ZLGA, X0, X0, X0);               // neg
    add_vec(32'h88000000, 0, 5, w(DR, LZ, GB, 0), ZLGA, X0, X0, X0);               // not
    add_vec(32'h08000000, 0, 6, BAY, CZ, ZLGA, X0, X0);                            // ldi
    add_vec(32'h00000000, 0, 8, BAY, CZ, ZLMAR, LDRD, w(DMDR, LREN, GA, 0));       // ld
    add_vec(32'h10000000, 0, 8, BAY, CZ, ZLMAR, w(DR, LMDR, GA, 0), w(DMDR, LRAM, 0, FMEM)); // st
    add_vec(32'h90000000, 0, 7, w(DR, LCON, GA, 0), w(DPC, LY, 0, 0), CZ, w(DZL, 12'h0, 0, 0), X0); // br not taken
    add_vec(32'h90000000, 1, 7, w(DR, LCON, GA, 0), w(DPC, LY, 0, 0), CZ, w(DZL, LPC, 0, 0), X0);   // br taken
    add_vec(32'h98000000, 0, 4, w(DR, LPC, GA, 0), X0, X0, X0, X0);                // jr
    add_vec(32'hA0000000, 0, 5, JAL1, w(DR, LPC, GA, 0), X0, X0, X0);              // jal
    add_vec(32'hB8000000, 0, 4, w(DHI, LREN, GA, 0), X0, X0, X0, X0);              // mfhi
    add_vec(32'hC0000000, 0, 4, w(DLO, LREN, GA, 0), X0, X0, X0, X0);              // mflo
    add_vec(32'hA8000000, 0, 4, w(DIN, LREN, GA, 0), X0, X0, X0, X0);              // in
    add_vec(32'hB0000000, 0, 4, w(DR, LOUT, GA, 0), X0, X0, X0, X0);               // out
    add_vec(32'hC8000000, 0, 4, w(-1, 12'h0, 0, 0), X0, X0, X0, X0);               // nop

    do_reset(1000);

    // Zero-wait instruction table, back to back
    for (int v = 0; v < nv; v++)
      for (int i = 0; i < int'(tv[v].n); i++)
        cyc((i < 3) ? fw[i] : body[v][i-3], tv[v].ir, tv[v].con, 1'b1, 1'b0, 1'b0);

    // ld with three wait cycles in fetch and in the read state
    cyc(fw[0], 32'h0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(fw[1], 32'h0, 0, (k == 3), 0, 0);
    cyc(fw[2], 32'h0, 0, 1, 0, 0);
    cyc(BAY, 32'h0, 0, 1, 0, 0);
    cyc(CZ, 32'h0, 0, 1, 0, 0);
    cyc(ZLMAR, 32'h0, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++) cyc(LDRD, 32'h0, 0, (k == 3), 0, 0);
    cyc(w(DMDR, LREN, GA, 0), 32'h0, 0, 1, 0, 0);

    // Stop raised mid-instruction and held to the boundary: add completes, then HALT
    for (int i = 0; i < 3; i++) cyc(fw[i], 32'h18000000, 0, 1, 0, 0);
    cyc(GRBY, 32'h18000000, 0, 1, 1, 0);
    cyc(GRCZ, 32'h18000000, 0, 1, 1, 0);
    cyc(ZLGA, 32'h18000000, 0, 1, 1, 0);
    cyc(HALTW, 32'h18000000, 0, 1, 1, 1);
    cyc(HALTW, 32'h18000000, 0, 1, 1, 1);
    cyc(HALTW, 32'h18000000, 0, 1, 0, 1);

    // Stop that drops before the boundary is ignored
    for (int i = 0; i < 3; i++) cyc(fw[i], 32'h18000000, 0, 1, 0, 0);
    cyc(GRBY, 32'h18000000, 0, 1, 1, 0);
    cyc(GRCZ, 32'h18000000, 0, 1, 0, 0);
    cyc(ZLGA, 32'h18000000, 0, 1, 0, 0);

    // halt opcode parks until Resume
    for (int i = 0; i < 3; i++) cyc(fw[i], 32'hD0000000, 0, 1, 0, 0);
    cyc(HALTW, 32'hD0000000, 0, 1, 0, 0);
    cyc(HALTW, 32'hD0000000, 0, 1, 0, 1);

    // Exactly MEM_TIMEOUT waits, ready on the final allowed cycle: normal completion
    cyc(fw[0], 32'hC8000000, 0, 1, 0, 0);
    for (int k = 0; k < 16; k++) cyc(fw[1], 32'hC8000000, 0, (k == 15), 0, 0);
    cyc(fw[2], 32'hC8000000, 0, 1, 0, 0);
    cyc(X0 | w(-1, 12'h0, 0, 0), 32'hC8000000, 0, 1, 0, 0);

    // Ready never arrives: FLT with sticky Fault, cleared only by Reset
    cyc(fw[0], 32'hC8000000, 0, 0, 0, 0);
    for (int k = 0; k < 16; k++) cyc(fw[1], 32'hC8000000, 0, 0, 0, 0);
    cyc(FLTW, 32'hC8000000, 0, 1, 0, 0);
    cyc(FLTW, 32'hC8000000, 0, 1, 0, 1);
    do_reset(2000);

    // Illegal opcode: ILL with Fault, Resume ignored, Reset clears
    for (int i = 0; i < 3; i++) cyc(fw[i], 32'hF8000000, 0, 1, 0, 0);
    cyc(FLTW, 32'hF8000000, 0, 1, 0, 1);
    cyc(FLTW, 32'hF8000000, 0, 1, 0, 0);
    do_reset(3000);

    // Reset in the middle of an instruction, then a clean add
    for (int i = 0; i < 3; i++) cyc(fw[i], 32'h18000000, 0, 1, 0, 0);
    cyc(GRBY, 32'h18000000, 0, 1, 0, 0);
    do_reset(4000);
    for (int i = 0; i < 3; i++) cyc(fw[i], 32'h18000000, 0, 1, 0, 0);
    cyc(GRBY, 32'h18000000, 0, 1, 0, 0);
    cyc(GRCZ, 32'h18000000, 0, 1, 0, 0);
    cyc(ZLGA, 32'h18000000, 0, 1, 0, 0);
    cyc(fw[0], 32'h18000000, 0, 1, 0, 0);

    @(negedge Clock);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain got=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
